// File: rtl/sram_ctrl.sv
// Synchronous controller for CHIPS side-by-side 16-bit asynchronous SRAMs.
// It turns a valid/ready request into registered CS/OE/WE/LB/UB/IO pin cycles.
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 17,
    parameter int CHIPS       = 2,
    parameter int WAIT_CYCLES = 1     // extra ACCESS cycles, 0..15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [16*CHIPS-1:0]     req_wdata,
    input  logic [2*CHIPS-1:0]      req_be,
    output logic                    rsp_valid,
    output logic [16*CHIPS-1:0]     rsp_rdata,
    output logic                    sram_cs1_n,
    output logic                    sram_cs2,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [CHIPS-1:0]        sram_lb_n,
    output logic [CHIPS-1:0]        sram_ub_n,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    inout  wire  [16*CHIPS-1:0]     sram_io
);

    localparam int DW = 16 * CHIPS;
    localparam int BW = 2 * CHIPS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    op_we_q;
    logic                    drive_q;
    logic [DW-1:0]           wdata_q;
    logic                    ready_q;
    logic                    cs1_n_q;
    logic                    cs2_q;
    logic                    oe_n_q;
    logic                    we_n_q;
    logic [CHIPS-1:0]        lb_n_q;
    logic [CHIPS-1:0]        ub_n_q;
    logic [ADDR_WIDTH-1:0]   a_q;
    logic                    rsp_valid_q;
    logic [DW-1:0]           rdata_q;
    logic                    accept_d;

    function automatic logic [CHIPS-1:0] lane_n(input logic [BW-1:0] be, input int hi);
        logic [CHIPS-1:0] r;
        r = '1;
        for (int i = 0; i < CHIPS; i++) begin
            r[i] = ~be[2*i + hi];
        end
        return r;
    endfunction

    assign accept_d = req_valid && ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            drive_q     <= 1'b0;
            ready_q     <= 1'b1;
            cs1_n_q     <= 1'b1;
            cs2_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= '1;
            ub_n_q      <= '1;
            a_q         <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q <= S_SETUP;
                        cnt_q   <= WAIT_INIT;
                        op_we_q <= req_we;
                        drive_q <= req_we;
                        ready_q <= 1'b0;
                        cs1_n_q <= 1'b0;
                        cs2_q   <= 1'b1;
                        oe_n_q  <= req_we;
                        a_q     <= req_addr;
                        // Reads enable every byte lane; writes mask by byte enable.
                        lb_n_q  <= req_we ? lane_n(req_be, 0) : '0;
                        ub_n_q  <= req_we ? lane_n(req_be, 1) : '0;
                    end
                end
                S_SETUP: begin
                    state_q <= S_ACCESS;
                    we_n_q  <= ~op_we_q;
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_HOLD;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (!op_we_q) begin
                            rdata_q     <= sram_io;
                            rsp_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    cs1_n_q <= 1'b1;
                    cs2_q   <= 1'b0;
                    drive_q <= 1'b0;
                    lb_n_q  <= '1;
                    ub_n_q  <= '1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write data is only driven behind drive_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            wdata_q <= req_wdata;
        end
    end

    assign sram_io    = drive_q ? wdata_q : {DW{1'bz}};
    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign sram_cs1_n = cs1_n_q;
    assign sram_cs2   = cs2_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_a     = a_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (1 and 3 wait states) on behavioural SRAMs,
// pin timing and read data checked against a word-level memory model.
module tb_sram_ctrl;

    localparam int AW = 17;
    localparam int CH = 2;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NI = 2;

    function automatic int wt(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]          rst, req_valid, req_ready, req_we, rsp_valid;
    logic [NI-1:0]          cs1_n, cs2, oe_n, we_n;
    logic [NI-1:0][AW-1:0]  req_addr, sram_a;
    logic [NI-1:0][DW-1:0]  req_wdata, rsp_rdata, io_val, tb_dat;
    logic [NI-1:0][BW-1:0]  req_be, tb_en;
    logic [NI-1:0][CH-1:0]  lb_n, ub_n;

    generate
        for (genvar g = 0; g < NI; g++) begin : gi
            wire [DW-1:0] io;
            sram_ctrl #(.ADDR_WIDTH(AW), .CHIPS(CH), .WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
                .clk(clk), .rst(rst[g]),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
                .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
                .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
                .sram_cs1_n(cs1_n[g]), .sram_cs2(cs2[g]), .sram_oe_n(oe_n[g]),
                .sram_we_n(we_n[g]), .sram_lb_n(lb_n[g]), .sram_ub_n(ub_n[g]),
                .sram_a(sram_a[g]), .sram_io(io));
            assign io_val[g] = io;
            for (genvar b = 0; b < BW; b++) begin : gb
                assign io[8*b +: 8] = tb_en[g][b] ? tb_dat[g][8*b +: 8] : 8'bz;
            end
        end
    endgenerate

    // Pin-level SRAM chips: 256 words each, indexed by the low address bits.
    logic [15:0] smem [NI][CH][256];
    bit sm_init = 1'b0;
    always @(negedge clk) begin
        if (!sm_init) begin
            for (int g = 0; g < NI; g++)
                for (int c = 0; c < CH; c++)
                    for (int a = 0; a < 256; a++) smem[g][c][a] <= 16'h0;
            sm_init <= 1'b1;
        end else begin
            for (int g = 0; g < NI; g++)
                for (int c = 0; c < CH; c++)
                    if (!cs1_n[g] && cs2[g] && !we_n[g]) begin
                        if (!lb_n[g][c]) smem[g][c][sram_a[g][7:0]][7:0]  <= io_val[g][16*c +: 8];
                        if (!ub_n[g][c]) smem[g][c][sram_a[g][7:0]][15:8] <= io_val[g][16*c+8 +: 8];
                    end
        end
    end

    // Reference state kept by the monitor.
    int                p[NI] = '{0, 0};
    logic              op_we[NI] = '{1'b0, 1'b0};
    logic [DW-1:0]     op_wd[NI];
    logic [BW-1:0]     op_be[NI];
    logic [AW-1:0]     op_a[NI];
    int                last_acc[NI];
    bit                held[NI];
    int                we_low[NI], oe_low[NI];
    logic [DW-1:0]     ref_mem [NI][256];
    typedef struct { logic [DW-1:0] d; int c; } exp_t;
    exp_t              sb[NI][$];

    // When the DUT must not drive, the bench pulls the idle bus to zero so a stray driver shows up.
    always_comb begin
        tb_en  = '0;
        tb_dat = '0;
        for (int g = 0; g < NI; g++) begin
            if (oe_n[g] && !(p[g] != 0 && op_we[g])) begin
                tb_en[g] = '1;
            end else if (!cs1_n[g] && cs2[g] && !oe_n[g] && we_n[g]) begin
                for (int c = 0; c < CH; c++) begin
                    tb_dat[g][16*c +: 16] = smem[g][c][sram_a[g][7:0]];
                    tb_en[g][2*c]         = !lb_n[g][c];
                    tb_en[g][2*c+1]       = !ub_n[g][c];
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    bit final_chk = 1'b0;
    bit final_done = 1'b0;
    bit rm_init = 1'b0;

    task automatic chk(input int g, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [inst %0d cycle %0d]: got %h, expected %h", nm, g, cyc, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] lane_exp(input logic [BW-1:0] be, input int hi);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = ~be[2*c + hi];
        return r;
    endfunction

    always @(negedge clk) begin
        int w;
        bit idle, setup, access, hold, probe;
        exp_t e;
        if (!rm_init) begin
            for (int g = 0; g < NI; g++)
                for (int a = 0; a < 256; a++) ref_mem[g][a] = '0;
            rm_init = 1'b1;
        end
        for (int g = 0; g < NI; g++) begin
            w = wt(g);
            probe = oe_n[g] && !(p[g] != 0 && op_we[g]);
            if (rst[g]) begin
                chk(g, "reset req_ready", req_ready[g], 1);
                chk(g, "reset cs1_n", cs1_n[g], 1);
                chk(g, "reset cs2", cs2[g], 0);
                chk(g, "reset oe_n", oe_n[g], 1);
                chk(g, "reset we_n", we_n[g], 1);
                chk(g, "reset lb_n", lb_n[g], {CH{1'b1}});
                chk(g, "reset ub_n", ub_n[g], {CH{1'b1}});
                chk(g, "reset sram_a", sram_a[g], 0);
                chk(g, "reset rsp_valid", rsp_valid[g], 0);
                chk(g, "reset rsp_rdata", rsp_rdata[g], 0);
                if (probe) chk(g, "reset bus released", io_val[g], 0);
                p[g] = 0;
                held[g] = 1'b0;
                sb[g].delete();
            end else begin
                idle   = (p[g] == 0);
                setup  = (p[g] == 1);
                access = (p[g] >= 2) && (p[g] <= w + 2);
                hold   = (p[g] == w + 3);
                chk(g, "req_ready", req_ready[g], idle);
                chk(g, "cs1_n", cs1_n[g], idle);
                chk(g, "cs2", cs2[g], !idle);
                chk(g, "oe_n", oe_n[g], !(!idle && !op_we[g] && (setup || access)));
                chk(g, "we_n", we_n[g], !(!idle && op_we[g] && access));
                chk(g, "rsp_valid", rsp_valid[g], !idle && !op_we[g] && hold);
                chk(g, "oe_n and we_n both low", !oe_n[g] && !we_n[g], 0);
                if (!idle) chk(g, "sram_a", sram_a[g], op_a[g]);
                if (!idle && op_we[g]) chk(g, "write bus data", io_val[g], op_wd[g]);
                else if (probe) chk(g, "bus released", io_val[g], 0);
                if (idle) begin
                    chk(g, "idle lb_n", lb_n[g], {CH{1'b1}});
                    chk(g, "idle ub_n", ub_n[g], {CH{1'b1}});
                end else if (access && op_we[g]) begin
                    chk(g, "write lb_n", lb_n[g], lane_exp(op_be[g], 0));
                    chk(g, "write ub_n", ub_n[g], lane_exp(op_be[g], 1));
                end else if ((setup || access) && !op_we[g]) begin
                    chk(g, "read lb_n", lb_n[g], 0);
                    chk(g, "read ub_n", ub_n[g], 0);
                end
                if (!we_n[g]) we_low[g]++;
                if (!oe_n[g]) oe_low[g]++;
                if (rsp_valid[g]) begin
                    if (sb[g].size() == 0) begin
                        chk(g, "outstanding reads at rsp_valid", sb[g].size(), 1);
                    end else begin
                        e = sb[g].pop_front();
                        chk(g, "rsp_rdata", rsp_rdata[g], e.d);
                        // HOLD is the cycle after edge k+2+W.
                        chk(g, "read latency", cyc - e.c, w + 2);
                    end
                end
                if (hold) begin
                    if (op_we[g]) chk(g, "we_n low cycles", we_low[g], w + 1);
                    else          chk(g, "oe_n low cycles", oe_low[g], w + 2);
                    p[g] = 0;
                end else if (!idle) begin
                    p[g]++;
                end
                if (!req_valid[g]) held[g] = 1'b0;
                if (idle && req_valid[g]) begin
                    if (held[g]) chk(g, "back-to-back accept spacing", cyc + 1 - last_acc[g], w + 4);
                    last_acc[g] = cyc + 1;
                    held[g]  = 1'b1;
                    p[g]     = 1;
                    op_we[g] = req_we[g];
                    op_wd[g] = req_wdata[g];
                    op_be[g] = req_be[g];
                    op_a[g]  = req_addr[g];
                    we_low[g] = 0;
                    oe_low[g] = 0;
                    if (req_we[g]) begin
                        for (int b = 0; b < BW; b++)
                            if (req_be[g][b]) ref_mem[g][req_addr[g][7:0]][8*b +: 8] = req_wdata[g][8*b +: 8];
                    end else begin
                        sb[g].push_back('{d: ref_mem[g][req_addr[g][7:0]], c: cyc + 1});
                    end
                end
            end
        end
        if (final_chk && !final_done) begin
            for (int g = 0; g < NI; g++) chk(g, "reads still outstanding at end", sb[g].size(), 0);
            final_done = 1'b1;
        end
    end

    task automatic issue(input int g, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be, input bit keep);
        bit ok;
        ok = 1'b0;
        req_valid[g] = 1'b1;
        req_we[g]    = we;
        req_addr[g]  = a;
        req_wdata[g] = d;
        req_be[g]    = be;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[g] && !rst[g]) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL accept timeout [inst %0d]: req_ready=%0b, expected 1", g, req_ready[g]);
            $fatal(1, "request never accepted");
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid[g] = 1'b0;
    endtask

    task automatic rand_ops(input int g, input int n);
        int gap;
        bit keep;
        for (int i = 0; i < n; i++) begin
            gap  = $urandom_range(0, 2);
            keep = (gap == 0) && ($urandom_range(0, 1) == 1);
            issue(g, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom,
                  BW'($urandom_range(0, 15)), keep);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        req_valid[g] = 1'b0;
    endtask

    initial begin
        rst       = '1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = '0;
        @(posedge clk);
        #1;

        issue(0, 1'b1, 17'h2, 32'h12345678, 4'hF, 1'b0);
        issue(0, 1'b0, 17'h2, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 17'h2, 32'hAAAABBBB, 4'h3, 1'b0);
        issue(0, 1'b0, 17'h2, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 17'h4, 32'h44440404, 4'hF, 1'b0);
        issue(0, 1'b1, 17'h5, 32'h55550505, 4'hF, 1'b0);
        issue(0, 1'b0, 17'h4, 32'h0, 4'h0, 1'b1);
        issue(0, 1'b0, 17'h5, 32'h0, 4'h0, 1'b0);
        issue(0, 1'b1, 17'h2, 32'hFFFFFFFF, 4'h0, 1'b0);
        issue(0, 1'b0, 17'h2, 32'h0, 4'h0, 1'b0);

        // Abort a read in its ACCESS cycle.
        issue(0, 1'b0, 17'h4, 32'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        issue(0, 1'b1, 17'h9, 32'h0BADBEEF, 4'hF, 1'b0);
        issue(0, 1'b0, 17'h9, 32'h0, 4'h0, 1'b0);
        rand_ops(0, 60);

        issue(1, 1'b1, 17'h2, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(1, 1'b0, 17'h2, 32'h0, 4'h0, 1'b0);
        rand_ops(1, 30);

        repeat (20) @(posedge clk);
        final_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
